sec_countdown: RTL and testbench

Down-counting minutes:seconds timer that sits opposite the up-counting seconds counter in the timekeeping chain. It is preloaded with a start time and decrements once per second, derived from the system clock by an internal prescaler, until it reaches 00:00. It then raises a one-cycle done pulse. It reuses the same `Clk`/`Reset`/`Slt` interface style, so one display driver can show either block.

---
 rtl/sec_countdown.sv | 143 ++++++++++++++
 tb/tb_sec_countdown.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sec_countdown.sv
// rtl/sec_countdown.sv - minutes:seconds down-counter with prescaler, pause/resume and done pulse
module sec_countdown #(
  parameter int CYCLES_PER_SEC = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic [5:0] Min_in,
  input  logic [5:0] Sec_in,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Slt,
  output logic [5:0] Min,
  output logic [5:0] Sec,
  output logic [5:0] Disp,
  output logic       Running,
  output logic       Tick,
  output logic       Done
);

  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
  localparam logic [5:0] MAX_FIELD = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;

  logic [5:0]      min_load, sec_load;
  logic [5:0]      min_dec, sec_dec;
  logic            time_zero, dec_zero, at_wrap;
  logic            do_pause, do_start, do_resume, do_count, do_dec;

  // Saturate load fields to 59 so the count never holds an out-of-range value
  always_comb begin
    min_load = (Min_in > MAX_FIELD) ? MAX_FIELD : Min_in;
    sec_load = (Sec_in > MAX_FIELD) ? MAX_FIELD : Sec_in;
  end

  // One-second-lower time value, borrowing a minute when seconds are at zero
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q;
    if (sec_q != 6'd0) begin
      sec_dec = sec_q - 6'd1;
    end else if (min_q != 6'd0) begin
      sec_dec = MAX_FIELD;
      min_dec = min_q - 6'd1;
    end
    dec_zero  = (min_dec == 6'd0) && (sec_dec == 6'd0);
    time_zero = (min_q == 6'd0) && (sec_q == 6'd0);
  end

  // Command decode: Load beats Pause beats Start; an asserted Pause also masks Start
  always_comb begin
    at_wrap   = (presc_q == PRESC_MAX);
    do_pause  = !Load && Pause && (state_q == ST_RUN);
    do_start  = !Load && !Pause && Start && (state_q == ST_IDLE) && !time_zero;
    do_resume = !Load && !Pause && Start && (state_q == ST_PAUSED);
    do_count  = !Load && !Pause && (state_q == ST_RUN);
    do_dec    = do_count && at_wrap;
  end

  // Next state: Load always returns to IDLE; reaching 00:00 by decrement expires
  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = ST_IDLE;
    end else if (do_pause) begin
      state_d = ST_PAUSED;
    end else if (do_start || do_resume) begin
      state_d = ST_RUN;
    end else if (do_dec && dec_zero) begin
      state_d = ST_EXPIRED;
    end
  end

  // Prescaler advances only while running; pause and resume leave it untouched
  always_comb begin
    presc_d = presc_q;
    if (Load || do_start) begin
      presc_d = '0;
    end else if (do_count) begin
      presc_d = at_wrap ? '0 : presc_q + 1'b1;
    end
  end

  // Time registers: load value, or one second less on a prescaler wrap
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (Load) begin
      min_d = min_load;
      sec_d = sec_load;
    end else if (do_dec) begin
      min_d = min_dec;
      sec_d = sec_dec;
    end
  end

  // Pulses registered alongside the new count so they line up with it
  always_comb begin
    tick_d = do_dec;
    done_d = do_dec && dec_zero;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign Min     = min_q;
  assign Sec     = sec_q;
  assign Disp    = Slt ? min_q : sec_q;
  assign Running = (state_q == ST_RUN);
  assign Tick    = tick_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_sec_countdown.sv
// tb/tb_sec_countdown.sv - directed and randomized checks of sec_countdown against a seconds-total model
module tb_sec_countdown;

  localparam int CPS = 4;

  logic       Clk = 1'b0;
  logic       Reset, Load, Start, Pause, Slt;
  logic [5:0] Min_in, Sec_in;
  logic [5:0] Min, Sec, Disp;
  logic       Running, Tick, Done;

  sec_countdown #(.CYCLES_PER_SEC(CPS)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Min_in(Min_in), .Sec_in(Sec_in),
    .Start(Start), .Pause(Pause), .Slt(Slt), .Min(Min), .Sec(Sec), .Disp(Disp),
    .Running(Running), .Tick(Tick), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  int last_tick_cyc = -1;
  int k;

  // reference model: mode 0 idle, 1 run, 2 paused, 3 expired; time kept as total seconds
  int m_mode = 0;
  int m_total = 0;
  int m_elapsed = 0;
  int m_tick = 0;
  int m_done = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic model_edge();
    m_tick = 0;
    m_done = 0;
    if (Reset) begin
      m_mode = 0; m_total = 0; m_elapsed = 0;
    end else if (Load) begin
      m_total = clamp59(int'(Min_in)) * 60 + clamp59(int'(Sec_in));
      m_elapsed = 0;
      m_mode = 0;
    end else if (Pause) begin
      if (m_mode == 1) m_mode = 2;
    end else if (Start && m_mode == 0 && m_total > 0) begin
      m_mode = 1; m_elapsed = 0;
    end else if (Start && m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_elapsed++;
      if (m_elapsed == CPS) begin
        m_elapsed = 0;
        m_total--;
        m_tick = 1;
        if (m_total == 0) begin
          m_done = 1;
          m_mode = 3;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    cyc++;
    #1;
    check_val("min", 32'(Min), 32'(m_total / 60));
    check_val("sec", 32'(Sec), 32'(m_total % 60));
    check_val("running", 32'(Running), 32'(m_mode == 1));
    check_val("tick", 32'(Tick), 32'(m_tick));
    check_val("done", 32'(Done), 32'(m_done));
    check_val("disp", 32'(Disp), Slt ? 32'(m_total / 60) : 32'(m_total % 60));
    if (Tick) begin tick_cnt++; last_tick_cyc = cyc; end
    if (Done) done_cnt++;
    Reset = 1'b0; Load = 1'b0; Start = 1'b0; Pause = 1'b0;
  endtask

  task automatic load_time(input int mm, input int ss);
    Load = 1'b1; Min_in = 6'(mm); Sec_in = 6'(ss);
    step();
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; Start = 1'b0; Pause = 1'b0; Slt = 1'b0;
    Min_in = 6'd0; Sec_in = 6'd0;
    step();

    // 1: 0:03 counts to zero, one done, then stays expired
    load_time(0, 3);
    Start = 1'b1; step(); k = cyc;
    tick_cnt = 0; done_cnt = 0;
    repeat (12) step();
    check_val("s1_ticks", 32'(tick_cnt), 32'd3);
    check_val("s1_done", 32'(done_cnt), 32'd1);
    check_val("s1_last_tick", 32'(last_tick_cyc), 32'(k + 12));
    check_val("s1_running", 32'(Running), 32'd0);
    tick_cnt = 0; done_cnt = 0;
    Start = 1'b1; step();
    repeat (19) step();
    check_val("s1_hold_ticks", 32'(tick_cnt), 32'd0);
    check_val("s1_hold_done", 32'(done_cnt), 32'd0);
    check_val("s1_hold_sec", 32'(Sec), 32'd0);

    // 2: 1:00 borrows into 0:59
    load_time(1, 0);
    Start = 1'b1; step();
    repeat (4) step();
    check_val("s2_sec", 32'(Sec), 32'd59);
    check_val("s2_min", 32'(Min), 32'd0);
    check_val("s2_tick", 32'(Tick), 32'd1);
    check_val("s2_done", 32'(Done), 32'd0);
    Slt = 1'b1; #1;
    check_val("s2_disp_min", 32'(Disp), 32'd0);
    Slt = 1'b0; #1;
    check_val("s2_disp_sec", 32'(Disp), 32'd59);

    // 3: pause spanning 10 edges (pause edge through start edge) delays the next tick by 10
    load_time(0, 5);
    Start = 1'b1; step(); k = cyc;
    repeat (5) step();
    Pause = 1'b1; step();
    tick_cnt = 0;
    repeat (8) step();
    Start = 1'b1; step();
    check_val("s3_paused_ticks", 32'(tick_cnt), 32'd0);
    repeat (3) step();
    check_val("s3_resume_tick", 32'(last_tick_cyc), 32'(k + 8 + 10));
    check_val("s3_tick_cnt", 32'(tick_cnt), 32'd1);

    // 4: saturation, and start at 00:00 is ignored
    load_time(63, 60);
    check_val("s4_min", 32'(Min), 32'd59);
    check_val("s4_sec", 32'(Sec), 32'd59);
    Reset = 1'b1; step();
    tick_cnt = 0;
    Start = 1'b1; step();
    check_val("s4_running", 32'(Running), 32'd0);
    repeat (6) step();
    check_val("s4_no_tick", 32'(tick_cnt), 32'd0);

    // 5: load coinciding with the wrap wins
    load_time(0, 1);
    Start = 1'b1; step();
    repeat (3) step();
    tick_cnt = 0; done_cnt = 0;
    Load = 1'b1; Min_in = 6'd0; Sec_in = 6'd2; step();
    check_val("s5_sec", 32'(Sec), 32'd2);
    check_val("s5_running", 32'(Running), 32'd0);
    check_val("s5_tick", 32'(Tick), 32'd0);
    check_val("s5_done", 32'(Done), 32'd0);
    repeat (6) step();
    check_val("s5_idle_sec", 32'(Sec), 32'd2);
    check_val("s5_no_pulses", 32'(tick_cnt + done_cnt), 32'd0);

    // 6: reset mid-run clears everything, no done
    load_time(0, 2);
    Start = 1'b1; step();
    done_cnt = 0;
    repeat (4) step();
    Reset = 1'b1; step();
    check_val("s6_sec", 32'(Sec), 32'd0);
    check_val("s6_running", 32'(Running), 32'd0);
    check_val("s6_tick", 32'(Tick), 32'd0);
    repeat (12) step();
    check_val("s6_done_cnt", 32'(done_cnt), 32'd0);

    // randomized mix of commands
    repeat (3000) begin
      Reset  = ($urandom % 150) == 0;
      Load   = ($urandom % 40) == 0;
      Pause  = ($urandom % 25) == 0;
      Start  = ($urandom % 8) == 0;
      Slt    = 1'($urandom % 2);
      Min_in = (($urandom % 8) == 0) ? 6'($urandom % 64) : 6'($urandom % 2);
      Sec_in = (($urandom % 4) == 0) ? 6'($urandom % 64) : 6'($urandom % 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
